// File: rtl/vga_timing_gen.sv
// Purpose : 640x480@60 VGA raster timing: pixel strobe, DAC clock, coords, syncs, blank, frame strobe/count.
// Latency : every raster output is registered and decoded from next-state counters, so all change on the same edge.
// Backpress: none; free-running raster, synchronous active-low reset parks it on the last pixel of a frame.
//
// Ports:
//   clk           system clock
//   rst           synchronous reset, active-low
//   pix_en        one-clk pixel strobe every CLK_DIV clks; raster advances on that edge
//   VGA_CLK       DAC pixel clock (low right after an advance, rises mid-pixel)
//   VGA_HS/VGA_VS active-low syncs
//   VGA_BLANK_N   low outside active video
//   VGA_SYNC_N    composite sync to DAC, tied low
//   x, y          raster position
//   active_pixels inside the visible area
//   frame_done    one-clk pulse on entry to vertical blanking
//   frame_count   frames completed, wraps at 256
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active_pixels,
    output logic       frame_done,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;
    logic [9:0]       x_nxt;
    logic [9:0]       y_nxt;
    logic             hs_nxt;
    logic             vs_nxt;
    logic             act_nxt;
    logic             enter_vblank;

    assign VGA_SYNC_N = 1'b0;

    // Next-state counters; every registered output is decoded from these so
    // coordinates and syncs always describe the same pixel.
    always_comb begin
        pix_en  = (div == DIV_LAST);
        div_nxt = pix_en ? '0 : div + 1'b1;
        x_nxt   = x;
        y_nxt   = y;
        if (pix_en) begin
            if (x == H_LAST) begin
                x_nxt = '0;
                y_nxt = (y == V_LAST) ? '0 : y + 10'd1;
            end else begin
                x_nxt = x + 10'd1;
            end
        end
        hs_nxt  = !((x_nxt >= HS_START) && (x_nxt < HS_END));
        vs_nxt  = !((y_nxt >= VS_START) && (y_nxt < VS_END));
        act_nxt = (x_nxt < H_ACT) && (y_nxt < V_ACT);
        // Gate with pix_en: without it the raster sits on (0,V_ACTIVE) for
        // CLK_DIV clks and the strobe would stretch.
        enter_vblank = pix_en && (x_nxt == '0) && (y_nxt == V_ACT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div           <= '0;
            x             <= H_LAST;
            y             <= V_LAST;
            VGA_CLK       <= 1'b0;
            VGA_HS        <= 1'b1;
            VGA_VS        <= 1'b1;
            VGA_BLANK_N   <= 1'b0;
            active_pixels <= 1'b0;
            frame_done    <= 1'b0;
            frame_count   <= '0;
        end else begin
            div           <= div_nxt;
            x             <= x_nxt;
            y             <= y_nxt;
            VGA_CLK       <= (div_nxt >= DIV_HALF);
            VGA_HS        <= hs_nxt;
            VGA_VS        <= vs_nxt;
            VGA_BLANK_N   <= act_nxt;
            active_pixels <= act_nxt;
            frame_done    <= enter_vblank;
            if (enter_vblank) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Purpose : checks vga_timing_gen against an arithmetic raster model (position derived from clocks since reset release).
// Latency : outputs sampled 1 time unit after each rising edge and compared every clk.
// Backpress: n/a; stimulus is a long reset-free run followed by randomly placed resets.
module tb_vga_timing_gen;

    // Shrunk raster so hundreds of frames fit in a short run.
    localparam int CLK_DIV  = 2;
    localparam int H_ACTIVE = 4;
    localparam int H_FP     = 1;
    localparam int H_SYNC   = 2;
    localparam int H_BP     = 1;
    localparam int V_ACTIVE = 3;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int NPIX     = H_TOTAL * V_TOTAL;
    localparam int FRAME_CLKS = NPIX * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pix_en, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
    logic [9:0] x, y;
    logic       active_pixels, frame_done;
    logic [7:0] frame_count;

    int n_checks = 0;
    int n_errors = 0;

    vga_timing_gen #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS),
        .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
        .x(x), .y(y), .active_pixels(active_pixels), .frame_done(frame_done),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model state: clocks since reset release.
    int t = 0;

    // Measurement state for the reset-free run.
    bit measure = 0;
    int cyc = 0;
    int hs_run = 0, vs_run = 0;
    int hs_last_fall = -1, vs_last_fall = -1;
    logic hs_prev = 1'b1, vs_prev = 1'b1;
    int act_cnt = 0;
    int fd_cnt = 0;

    // Compare every output against the position implied by t.
    task automatic compare_model();
        int d, n, lin, ex, ey, k0, efc;
        bit e_act, e_hs, e_vs, e_fd;
        d   = t % CLK_DIV;
        n   = t / CLK_DIV;
        lin = (NPIX - 1 + n) % NPIX;
        ex  = lin % H_TOTAL;
        ey  = lin / H_TOTAL;
        e_act = (ex < H_ACTIVE) && (ey < V_ACTIVE);
        e_hs  = !((ex >= H_ACTIVE + H_FP) && (ex < H_ACTIVE + H_FP + H_SYNC));
        e_vs  = !((ey >= V_ACTIVE + V_FP) && (ey < V_ACTIVE + V_FP + V_SYNC));
        e_fd  = (d == 0) && (n > 0) && (lin == V_ACTIVE * H_TOTAL);
        // Advance k enters vblank when (NPIX-1+k) mod NPIX == V_ACTIVE*H_TOTAL.
        k0  = V_ACTIVE * H_TOTAL + 1;
        efc = (n >= k0) ? (((n - k0) / NPIX + 1) % 256) : 0;
        check("x", int'(x), ex);
        check("y", int'(y), ey);
        check("pix_en", int'(pix_en), int'(d == CLK_DIV - 1));
        check("vga_clk", int'(VGA_CLK), int'(d >= CLK_DIV / 2));
        check("active", int'(active_pixels), int'(e_act));
        check("blank_n", int'(VGA_BLANK_N), int'(e_act));
        check("hs", int'(VGA_HS), int'(e_hs));
        check("vs", int'(VGA_VS), int'(e_vs));
        check("sync_n", int'(VGA_SYNC_N), 0);
        check("frame_done", int'(frame_done), int'(e_fd));
        check("frame_count", int'(frame_count), efc);
    endtask

    // Interval measurements taken directly on the output waveforms.
    task automatic measure_waves();
        if (VGA_HS == 1'b0) hs_run++;
        else if (hs_run > 0) begin
            check("hs_width", hs_run, H_SYNC * CLK_DIV);
            hs_run = 0;
        end
        if (VGA_VS == 1'b0) vs_run++;
        else if (vs_run > 0) begin
            check("vs_width", vs_run, V_SYNC * H_TOTAL * CLK_DIV);
            vs_run = 0;
        end
        if (hs_prev && !VGA_HS) begin
            check("hs_fall_x", int'(x), H_ACTIVE + H_FP);
            if (hs_last_fall >= 0) check("hs_period", cyc - hs_last_fall, H_TOTAL * CLK_DIV);
            hs_last_fall = cyc;
        end
        if (vs_prev && !VGA_VS) begin
            check("vs_fall_x", int'(x), 0);
            check("vs_fall_y", int'(y), V_ACTIVE + V_FP);
            if (vs_last_fall >= 0) check("vs_period", cyc - vs_last_fall, FRAME_CLKS);
            vs_last_fall = cyc;
        end
        hs_prev = VGA_HS;
        vs_prev = VGA_VS;
        if (pix_en && active_pixels) act_cnt++;
        if (frame_done) begin
            fd_cnt++;
            check("fd_x", int'(x), 0);
            check("fd_y", int'(y), V_ACTIVE);
            check("act_per_frame", act_cnt, H_ACTIVE * V_ACTIVE);
            act_cnt = 0;
            if (fd_cnt == 256) check("fc_wrap", int'(frame_count), 0);
            if (fd_cnt == 257) check("fc_after_257", int'(frame_count), 1);
        end
        cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) t = 0;
        else t++;
        #1;
        compare_model();
        if (measure) measure_waves();
    endtask

    initial begin
        // Reset held for 5 clks parks the raster on the last pixel.
        rst = 1'b0;
        repeat (5) step();
        check("rst_x", int'(x), H_TOTAL - 1);
        check("rst_y", int'(y), V_TOTAL - 1);
        check("rst_hs", int'(VGA_HS), 1);
        check("rst_vs", int'(VGA_VS), 1);

        // Release: second edge lands on (0,0) with active video.
        rst = 1'b1;
        measure = 1;
        step();
        step();
        check("first_x", int'(x), 0);
        check("first_y", int'(y), 0);
        check("first_active", int'(active_pixels), 1);
        check("first_blank_n", int'(VGA_BLANK_N), 1);

        // Reset-free run through 257 frame strobes, bounded by a cycle budget.
        for (int i = 0; i < 260 * FRAME_CLKS; i++) begin
            step();
            if (fd_cnt >= 257) break;
        end
        check("frames_seen", fd_cnt, 257);
        measure = 0;

        // Random resets at random raster positions, each 1..3 clks long.
        for (int r = 0; r < 40; r++) begin
            int run;
            run = $urandom_range(0, 3 * FRAME_CLKS);
            for (int i = 0; i < run; i++) step();
            rst = 1'b0;
            for (int i = 0; i < int'($urandom_range(1, 3)); i++) step();
            rst = 1'b1;
        end
        // Let the last restart reach its first vblank entry.
        for (int i = 0; i < FRAME_CLKS + 4; i++) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
